// File: rtl/pmem_responder_pkg.sv
// Line geometry, latency default and FSM state encoding for the
// physical memory responder model.
package pmem_responder_pkg;
    localparam int S_OFFSET    = 5;
    localparam int S_LINE      = 8 * (2 ** S_OFFSET);
    localparam int MEM_INDEX   = 8;
    localparam int LATENCY_DEF = 4;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/rv32i_types.sv
// Base RV32I scalar types shared across the core.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/pmem_array.sv
// Line-wide storage with one registered read port and one write port.
// Storage is never reset; only the read register is.
module pmem_array
    import pmem_responder_pkg::*;
#(
    parameter int s_line    = S_LINE,
    parameter int mem_index = MEM_INDEX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [mem_index-1:0] rd_idx,
    output logic [s_line-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [mem_index-1:0] wr_idx,
    input  logic [s_line-1:0]    wr_data
);
    logic [s_line-1:0] lines [2**mem_index];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= lines[rd_idx];
        end
    end
endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder: accepts one read or write,
// answers with a one-cycle pmem_resp LATENCY cycles later.
module pmem_responder
    import rv32i_types::*;
    import pmem_responder_pkg::*;
#(
    parameter int s_offset  = S_OFFSET,
    parameter int s_line    = S_LINE,
    parameter int mem_index = MEM_INDEX,
    parameter int LATENCY   = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  rv32i_word         pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [s_line-1:0] pmem_rdata,
    output logic              protocol_err
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 op_write;
    logic [mem_index-1:0] idx_q;
    logic [s_line-1:0]    wdata_q;

    logic [mem_index-1:0] addr_idx;
    logic                 one_req;
    logic                 both_req;
    logic                 rd_en;
    logic                 wr_en;
    logic [mem_index-1:0] rd_idx;
    logic                 unused_ok;

    assign addr_idx = pmem_address[s_offset+mem_index-1:s_offset];
    assign one_req  = pmem_read ^ pmem_write;
    assign both_req = pmem_read & pmem_write;
    assign unused_ok = ^{pmem_address[31:s_offset+mem_index],
                         pmem_address[s_offset-1:0]};

    // The read is launched on the edge that enters RESP so the
    // registered port presents data exactly in the RESP cycle.
    assign rd_en = !rst &&
        (((state == IDLE) && pmem_read && !pmem_write && (LATENCY == 1)) ||
         ((state == BUSY) && (cnt == 8'd1) && !op_write));
    assign rd_idx = (state == IDLE) ? addr_idx : idx_q;
    assign wr_en  = !rst && (state == RESP) && op_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pmem_resp    <= 1'b0;
            protocol_err <= 1'b0;
            op_write     <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
        end else begin
            pmem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (both_req) begin
                        protocol_err <= 1'b1;
                    end else if (one_req) begin
                        op_write <= pmem_write;
                        idx_q    <= addr_idx;
                        wdata_q  <= pmem_wdata;
                        cnt      <= LOAD;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state     <= RESP;
                        pmem_resp <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pmem_array #(
        .s_line    (s_line),
        .mem_index (mem_index)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (pmem_rdata),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q)
    );
endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: directed scenarios plus
// randomized traffic checked against a line-array reference model.
module tb_pmem_responder;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         protocol_err;

    pmem_responder #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  at_cyc;
        bit           rd;
        logic [255:0] data;
    } exp_t;

    exp_t         q[$];
    logic [255:0] model [256];
    logic [255:0] last_rd = '0;
    int unsigned  cyc = 0;
    int unsigned  free_edge = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 5) & 32'hFF);
    endfunction

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Monitor: every response must match the oldest pending expectation.
    always @(negedge clk) begin
        if (pmem_resp) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.at_cyc) begin
                    errors++;
                    $display("FAIL resp_timing: at cycle %0d expected %0d", cyc, e.at_cyc);
                end
                checks++;
                if (e.rd) begin
                    if (pmem_rdata !== e.data) begin
                        errors++;
                        $display("FAIL read_data: got %h expected %h", pmem_rdata, e.data);
                    end
                    last_rd = e.data;
                end else if (pmem_rdata !== last_rd) begin
                    errors++;
                    $display("FAIL rdata_held_on_write: got %h expected %h", pmem_rdata, last_rd);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the RESP cycle,
    // leaving the request lines as they are.
    task automatic issue(bit rd, logic [31:0] a, logic [255:0] d, bit scramble);
        exp_t        e;
        int unsigned acc;
        int          n;
        pmem_read    = rd;
        pmem_write   = !rd;
        pmem_address = a;
        pmem_wdata   = d;
        acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        e.at_cyc = acc + LAT - 1;
        e.rd     = rd;
        e.data   = model[idx_of(a)];
        if (!rd) model[idx_of(a)] = d;
        free_edge = e.at_cyc + 2;
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && cyc >= acc && !pmem_resp) begin
                pmem_address = $urandom;
                pmem_wdata   = rand_line();
                if ($urandom_range(0, 1) == 1) begin
                    pmem_read  = 1'b0;
                    pmem_write = 1'b0;
                end
            end
        end while (!pmem_resp && n < 40);
        if (!pmem_resp) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no pmem_resp for address %h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line_l;
        logic [255:0] line_x;
        for (int i = 0; i < 256; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_resp", pmem_resp, 1'b0);
        check_bit("reset_rdata_zero", pmem_rdata == '0, 1'b1);
        check_bit("reset_perr", protocol_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        free_edge = cyc + 1;

        issue(1'b0, 32'h0000_0040, {32{8'hA5}}, 1'b0);
        idle(1);
        issue(1'b1, 32'h0000_0040, '0, 1'b0);
        idle(2);
        issue(1'b1, 32'h0000_0100, '0, 1'b0);
        idle(1);

        line_l = rand_line();
        issue(1'b0, 32'h0000_0020, line_l, 1'b0);
        idle(1);
        issue(1'b1, 32'h0000_203F, '0, 1'b0);
        idle(2);

        pmem_read  = 1'b1;
        pmem_write = 1'b1;
        pmem_address = 32'h0000_0040;
        @(posedge clk);
        #1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        check_bit("perr_set", protocol_err, 1'b1);
        idle(6);
        @(negedge clk);
        check_bit("perr_sticky", protocol_err, 1'b1);
        @(posedge clk);
        #1;
        issue(1'b1, 32'h0000_0020, '0, 1'b0);
        check_bit("perr_still_set", protocol_err, 1'b1);

        issue(1'b1, 32'h0000_0040, '0, 1'b0);
        issue(1'b1, 32'h0000_0020, '0, 1'b0);
        idle(2);

        line_x = rand_line();
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0040;
        pmem_wdata   = line_x;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_bit("rst_abort_resp", pmem_resp, 1'b0);
        check_bit("rst_rdata_zero", pmem_rdata == '0, 1'b1);
        check_bit("rst_perr_clear", protocol_err, 1'b0);
        last_rd = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        free_edge = cyc + 1;
        idle(3);
        issue(1'b1, 32'h0000_0040, '0, 1'b0);
        idle(1);

        for (int n = 0; n < 80; n++) begin
            bit           rd;
            logic [31:0]  a;
            rd = ($urandom_range(0, 1) == 1);
            a  = ($urandom & 32'hFFFF_E000)
               | (32'($urandom_range(0, 15)) << 5)
               | 32'($urandom_range(0, 31));
            issue(rd, a, rand_line(), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end

        idle(10);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_resp: %0d responses outstanding, expected 0", q.size());
        end
        check_bit("final_perr", protocol_err, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter s_offset, default 5: byte-offset bits within a line.
REQ-002 Parameter s_line, default 256: line width in bits (8*2**s_offset).
REQ-003 Parameter mem_index, default 8: log2 of stored lines (256 lines, 8 KB).
REQ-004 Parameter LATENCY, default 4, legal range 1..255: cycles from request acceptance to response.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 pmem_read  input  1  line read request, held until pmem_resp.
REQ-009 pmem_write  input  1  line write request, held until pmem_resp.
REQ-010 pmem_address  input  32 (rv32i_word)  byte address; offset bits ignored.
REQ-011 pmem_wdata  input  s_line  write line data.
REQ-012 pmem_resp  output  1  one-cycle completion pulse.
REQ-013 pmem_rdata  output  s_line  read line data, valid while pmem_resp=1 after a read.
REQ-014 protocol_err  output  1  sticky flag: pmem_read and pmem_write asserted together.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-016 IDLE: on an edge with exactly one of pmem_read/pmem_write high, latch op, line index pmem_address[s_offset+mem_index-1:s_offset] and pmem_wdata, load the counter with LATENCY-1, and go to BUSY (LATENCY=1 goes straight to RESP).
REQ-017 IDLE: on an edge with both requests high, set protocol_err, accept nothing and stay in IDLE.
REQ-018 BUSY: decrement the counter each cycle; at 1, go to RESP.
REQ-019 RESP: pmem_resp=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-020 A request sampled at edge t SHALL see pmem_resp high in cycle t+LATENCY.
REQ-021 Read: pmem_rdata SHALL be the stored line at the latched index, registered, presented in the RESP cycle and held until the next read response.
REQ-022 Write: the latched line SHALL be committed at the RESP-exit edge; pmem_rdata is unchanged by writes.
REQ-023 Address bits above s_offset+mem_index SHALL be ignored, so aliased addresses map to the same line.
REQ-024 Input changes or deassertion after acceptance SHALL be ignored; the transaction still completes and pulses pmem_resp.
REQ-025 A request present in the cycle after RESP SHALL be accepted normally, giving back-to-back transactions with no extra turnaround.
REQ-026 A read following a write to the same line SHALL return the written data.

Reset
REQ-027 While rst=1: state IDLE, counter 0, pmem_resp 0, pmem_rdata 0, protocol_err 0.
REQ-028 Reset mid-transaction SHALL abort it with no response; an uncommitted write is discarded.
REQ-029 Reset SHALL NOT clear line storage; storage starts all-zero in simulation.

Structure
REQ-030 rv32i_word comes from rv32i_types; the line-width and offset constants and the FSM state enum SHALL reside in the shared package.
REQ-031 Line storage SHALL be a sub-module pmem_array with one registered read port and one write port, indexed by line.

Verification (LATENCY=4)
REQ-032 Reset, then write 0xA5 repeated to 0x0000_0040, then read 0x0000_0040 -> each pmem_resp occurs 4 cycles after acceptance; read returns the 0xA5 line.
REQ-033 Read 0x0000_0100 after reset -> pmem_rdata all-zero with pmem_resp at t+4.
REQ-034 Write line L to 0x0000_0020, then read 0x0000_203F (mem_index=8 alias) -> returns L.
REQ-035 Assert read and write together in IDLE -> protocol_err=1 and stays set; no pmem_resp; next clean read completes.
REQ-036 Issue a write, assert rst 2 cycles after acceptance, release, then read the same line -> no pmem_resp for the write; read returns the old data.
REQ-037 Hold read through RESP with a new address driven the next cycle -> second pmem_resp exactly 5 cycles after the first, carrying the new line.
